// File: rtl/fifo_word_packer.sv
// Drains an 8-bit synchronous FIFO and packs bytes into BYTES_PER_WORD-wide words on a
// registered valid/ready stream. A flush emits the partial word with a byte-keep mask.
module fifo_word_packer #(
    parameter int DATA_W         = 8,
    parameter int BYTES_PER_WORD = 4,
    parameter int CNT_W          = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               fifo_empty,
    input  logic [DATA_W-1:0]                  fifo_data,
    output logic                               fifo_rd_en,
    input  logic                               flush,
    output logic                               flush_busy,
    output logic                               m_valid,
    input  logic                               m_ready,
    output logic [DATA_W*BYTES_PER_WORD-1:0]   m_data,
    output logic [BYTES_PER_WORD-1:0]          m_keep,
    output logic                               m_last,
    output logic [CNT_W-1:0]                   word_count
);

    localparam int N  = BYTES_PER_WORD;
    localparam int CW = $clog2(N + 1);

    localparam logic [1:0] S_FILL       = 2'd0;
    localparam logic [1:0] S_FLUSH_WAIT = 2'd1;
    localparam logic [1:0] S_FLUSH_EMIT = 2'd2;

    logic [1:0]          r_state;
    logic [CW-1:0]       r_asm_cnt;
    logic                r_rd_pend;
    logic [DATA_W-1:0]   r_asm [N];
    logic                r_m_valid;
    logic [DATA_W*N-1:0] r_m_data;
    logic [N-1:0]        r_m_keep;
    logic                r_m_last;
    logic [CNT_W-1:0]    r_word_count;

    logic                w_slot_free;
    logic                w_handoff;
    logic [CW:0]         w_fill_lvl;
    logic [CW-1:0]       w_cap_lane;
    logic [N-1:0]        w_keep;
    logic [DATA_W*N-1:0] w_word;

    assign w_slot_free = !r_m_valid || m_ready;
    // A flush seen alongside a full word takes priority so that word leaves with m_last set.
    assign w_handoff   = w_slot_free &&
                         ((r_state == S_FILL && r_asm_cnt == CW'(N) && !flush) ||
                          r_state == S_FLUSH_EMIT);
    assign w_fill_lvl  = {1'b0, r_asm_cnt} + {{CW{1'b0}}, r_rd_pend};
    assign fifo_rd_en  = !rst && !fifo_empty && (r_state == S_FILL) &&
                         (w_fill_lvl < (CW+1)'(N));
    assign w_cap_lane  = w_handoff ? '0 : r_asm_cnt;

    always_comb begin
        // NOTE: defaults first so every path assigns every bit and no latch is inferred.
        w_keep = '0;
        w_word = '0;
        for (int i = 0; i < N; i++) begin
            w_keep[i] = (CW'(i) < r_asm_cnt);
            if (w_keep[i]) begin
                w_word[i*DATA_W +: DATA_W] = r_asm[i];
            end
        end
    end

    // NOTE: the assembly lanes carry no reset; stale lanes are masked by w_keep on handoff.
    always_ff @(posedge clk) begin
        if (r_rd_pend) begin
            for (int i = 0; i < N; i++) begin
                if (w_cap_lane == CW'(i)) begin
                    r_asm[i] <= fifo_data;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_FILL;
            r_asm_cnt    <= '0;
            r_rd_pend    <= 1'b0;
            r_m_valid    <= 1'b0;
            r_m_data     <= '0;
            r_m_keep     <= '0;
            r_m_last     <= 1'b0;
            r_word_count <= '0;
        end else begin
            // NOTE: non-blocking so every register here samples the pre-edge values.
            r_rd_pend <= fifo_rd_en;

            if (w_handoff) begin
                r_asm_cnt <= r_rd_pend ? CW'(1) : '0;
            end else if (r_rd_pend) begin
                r_asm_cnt <= r_asm_cnt + CW'(1);
            end

            case (r_state)
                S_FILL: begin
                    if (flush) r_state <= S_FLUSH_WAIT;
                end
                S_FLUSH_WAIT: begin
                    if (!r_rd_pend) r_state <= (r_asm_cnt != '0) ? S_FLUSH_EMIT : S_FILL;
                end
                S_FLUSH_EMIT: begin
                    if (w_handoff) r_state <= S_FILL;
                end
                default: r_state <= S_FILL;
            endcase

            if (w_handoff) begin
                r_m_valid <= 1'b1;
                r_m_data  <= w_word;
                r_m_keep  <= w_keep;
                r_m_last  <= (r_state == S_FLUSH_EMIT);
            end else if (m_ready) begin
                r_m_valid <= 1'b0;
            end

            if (r_m_valid && m_ready) begin
                r_word_count <= r_word_count + CNT_W'(1);
            end
        end
    end

    assign flush_busy = (r_state != S_FILL);
    assign m_valid    = r_m_valid;
    assign m_data     = r_m_data;
    assign m_keep     = r_m_keep;
    assign m_last     = r_m_last;
    assign word_count = r_word_count;

endmodule
